// File: rtl/bus_arb_mux.sv
// Registered round-robin bus arbiter/multiplexer: NSRC requesters share one
// WIDTH-bit bus, with optional owner lock and multi-driver conflict flags.
module bus_arb_mux #(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 24,
    localparam int IDXW  = $clog2(NSRC)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] data_in,
    input  logic                  lock,
    input  logic                  err_clr,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [NSRC-1:0]       grant,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  conflict,
    output logic                  err_sticky
);

    localparam logic [IDXW:0]   NSRC_X   = (IDXW + 1)'(NSRC);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSRC - 1);

    logic [IDXW-1:0]  ptr_q,       ptr_d;
    logic [NSRC-1:0]  grant_q,     grant_d;
    logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
    logic [WIDTH-1:0] bus_q,       bus_d;
    logic             valid_q,     valid_d;
    logic             conflict_q,  conflict_d;
    logic             err_q,       err_d;

    logic [2*NSRC-1:0] req_rot;
    logic [NSRC-1:0]   req_rot_lo;
    logic [IDXW-1:0]   rr_off;
    logic              rr_found;
    logic [IDXW:0]     rr_sum;
    logic [IDXW-1:0]   rr_idx;

    logic              owner_hold;
    logic              win_valid;
    logic [IDXW-1:0]   win_idx;
    logic [WIDTH-1:0]  win_word;
    logic              multi_req;

    // Rotating the doubled request vector by ptr turns the circular search
    // into a plain lowest-set-bit search; the offset is then mapped back.
    always_comb begin : rr_search
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        req_rot    = {req, req} >> ptr_q;
        req_rot_lo = req_rot[NSRC-1:0];
        rr_off     = '0;
        rr_found   = 1'b0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (req_rot_lo[k]) begin
                rr_off   = IDXW'(k);
                rr_found = 1'b1;
            end
        end
        rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
        if (rr_sum >= NSRC_X) begin
            rr_sum = rr_sum - NSRC_X;
        end
        rr_idx = rr_sum[IDXW-1:0];
    end

    always_comb begin : arbitrate
        // grant_q is one-hot at grant_idx_q, so this tests req[grant_idx_q].
        owner_hold = lock && (|(grant_q & req));
        win_valid  = owner_hold || rr_found;
        win_idx    = owner_hold ? grant_idx_q : rr_idx;

        ptr_d = ptr_q;
        if (!owner_hold && rr_found) begin
            ptr_d = (rr_idx == LAST_IDX) ? '0 : rr_idx + IDXW'(1);
        end

        win_word = '0;
        grant_d  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (win_valid && (win_idx == IDXW'(i))) begin
                win_word   = data_in[i*WIDTH +: WIDTH];
                grant_d[i] = 1'b1;
            end
        end

        grant_idx_d = win_valid ? win_idx  : grant_idx_q;
        bus_d       = win_valid ? win_word : bus_q;
        valid_d     = win_valid;

        // Clearing the lowest set bit leaves something iff two or more were set.
        multi_req  = |(req & (req - NSRC'(1)));
        conflict_d = multi_req;
        err_d      = multi_req | (err_q & ~err_clr);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            bus_q       <= '0;
            valid_q     <= 1'b0;
            conflict_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            bus_q       <= bus_d;
            valid_q     <= valid_d;
            conflict_q  <= conflict_d;
            err_q       <= err_d;
        end
    end

    assign bus_out    = bus_q;
    assign bus_valid  = valid_q;
    assign grant      = grant_q;
    assign grant_idx  = grant_idx_q;
    assign conflict   = conflict_q;
    assign err_sticky = err_q;

endmodule

// File: doc/bus_arb_mux.md
# bus_arb_mux

Parametrised, registered successor to the datapath bus multiplexer. Instead of a static encoded select, NSRC sources each raise a request. A round-robin arbiter grants the bus to one source per cycle, and the granted source's word is registered onto the shared bus with a valid flag. The block also flags multi-driver conflicts and supports a lock mode for back-to-back ownership. It sits between the register file / special registers (HI, LO, Z, PC, MDR, port, sign-extended constant) and all bus consumers.

## Interface
Parameters:
- WIDTH, 32, bus word width in bits (≥1)
- NSRC, 24, number of bus sources (2..64)
- IDXW, $clog2(NSRC), width of the encoded grant index (derived; not overridden)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- clear  input  1  reset, asynchronous, active-high
- req  input  NSRC  per-source bus request; bit i = source i
- data_in  input  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH]
- lock  input  1  keep current owner while it continues requesting
- err_clr  input  1  clear sticky conflict error
- bus_out  output  WIDTH  registered bus word
- bus_valid  output  1  bus_out carries a word granted this cycle
- grant  output  NSRC  registered one-hot grant; all-zero when idle
- grant_idx  output  IDXW  registered index of granted source; holds last value when idle
- conflict  output  1  registered: more than one req bit was set in the previous cycle
- err_sticky  output  1  sticky conflict flag

## Operation
- State: grant, grant_idx, bus_out, bus_valid, conflict, err_sticky, rotating priority pointer ptr (IDXW bits, range 0..NSRC-1).
- Arbitration each cycle, evaluated combinationally from req, ptr, lock and the current grant:
  - If lock=1, grant≠0 and req[grant_idx]=1: the winner is grant_idx and ptr is unchanged.
  - Otherwise the winner is the first set req bit searching ptr, ptr+1, …, NSRC-1, 0, …, ptr-1 (mod NSRC).
  - When a winner w exists: next ptr = (w+1) mod NSRC, wrapping from NSRC-1 to 0.
  - When req = 0: no winner and ptr is unchanged.
- On a winner at the clock edge:
  - grant is set to a one-hot at w and grant_idx to w.
  - bus_out takes data_in[w*WIDTH +: WIDTH] as sampled at that edge.
  - bus_valid goes to 1.
- On no winner at the clock edge:
  - grant goes to 0 and bus_valid to 0.
  - bus_out and grant_idx hold their previous values; the bus is never driven to X.
- Conflict handling:
  - conflict is registered as (popcount(req) > 1) every cycle, regardless of lock.
  - err_sticky sets when popcount(req) > 1 and clears when err_clr=1.
  - If both happen in the same cycle, set wins.
- Lock with the owner dropping req: lock is ignored and normal round-robin resumes from ptr.
- req bits at or above NSRC do not exist; data_in is fully used with no padding.

## Timing
- Latency is 1 cycle: req/data_in sampled at edge k appear on grant/bus_out/bus_valid after edge k.
- Throughput: one grant per cycle and no bubbles between owners.
- A continuously requesting single source is granted every cycle.
- With N sources requesting continuously and lock=0, each source is granted once per N cycles in ascending index order (with wrap).
- Reset values (asynchronous, immediate on clear=1):
  - bus_out=0, bus_valid=0, grant=0, grant_idx=0
  - conflict=0, err_sticky=0, ptr=0, so source 0 has highest priority first
- Reset mid-grant: outputs go to their reset values without waiting for a clock edge. The first edge after clear deasserts arbitrates from ptr=0.
- No combinational path from inputs to any output.

## Test plan
- Reset and idle:
  - Stimulus: clear pulsed mid-stream with req=0x000010; then req=0 for 3 cycles.
  - Required: all outputs 0 immediately on clear; afterwards bus_valid=0, and bus_out/grant_idx hold their last values.
- Single source:
  - Stimulus: req=1<<21 with word 0xDEADBEEF on source 21.
  - Required: after 1 edge, grant=1<<21, grant_idx=21, bus_out=0xDEADBEEF, bus_valid=1, conflict=0.
- Round-robin fairness with wrap:
  - Stimulus: req bits {2,7,23} held for 6 cycles, lock=0.
  - Required: grant_idx sequence 2,7,23,2,7,23; conflict=1 each cycle; err_sticky=1.
- Lock:
  - Stimulus: req={3,5}, lock=1 from cycle 2; source 3 drops req at cycle 6.
  - Required: grant_idx sequence 3,3,3,3,3, then 5 once source 3 drops req.
- Sticky error clear:
  - Stimulus 1: conflict, then err_clr=1 with req=1<<0.
  - Required: err_sticky=0 after that edge.
  - Stimulus 2: err_clr=1 in the same cycle as req={0,1}.
  - Required: err_sticky stays 1.
- Parameter sweep:
  - Stimulus: repeat the round-robin test with WIDTH=8, NSRC=2 and with WIDTH=64, NSRC=64, using random data.
  - Required: bus_out always equals the granted source's sampled word.
